// File: rtl/if_lut_pkg.sv
// if_lut_pkg: shared constants and types for the IF-circuit lookup front end.
//   DATA_W / ADDR_W : sample, lookup-result and LUT address widths
//   FIFO_DEPTH      : result buffer depth (two slots: one in flight, one stalled)
//   lut_word_t      : one LUT word
package if_lut_pkg;
    localparam int DATA_W     = 12;
    localparam int ADDR_W     = 12;
    localparam int FIFO_DEPTH = 2;

    typedef logic [DATA_W-1:0] lut_word_t;
endpackage

// File: rtl/if_lut_fifo2.sv
// if_lut_fifo2: 2-entry synchronous FIFO, asynchronous active-low reset.
//   clk, rst_n  : clock, async active-low reset
//   push, din   : write request and data (caller guarantees not full)
//   pop         : read request (caller guarantees not empty)
//   dout        : head entry (combinational from storage, 0 after reset)
//   count       : occupancy 0..2
//   full, empty : occupancy flags
module if_lut_fifo2 #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);
    import if_lut_pkg::*;

    logic [W-1:0] mem [FIFO_DEPTH];
    // 1-bit pointers wrap naturally modulo 2
    logic         wptr;
    logic         rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            // simultaneous push and pop leaves occupancy unchanged
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
endmodule

// File: rtl/if_table_lookup_ctrl.sv
// if_table_lookup_ctrl: streaming front end for the IF-circuit lookup RAM.
// Each accepted sample is issued as a port-A read address; the registered RAM
// output is captured one cycle later into a 2-entry result FIFO and streamed out.
// Optional macro IF_LUT_SPIKE_DET_EN enables the spike comparator and counter;
// without it spike/spike_cnt are tied to 0 (ports kept).
//   clk, rst_n           : clock (also RAM port A clock), async active-low reset
//   in_valid/in_ready    : sample handshake, in_data is the LUT address
//   lut_addr/en/we/din   : RAM port A controls (write side tied off)
//   lut_dout             : RAM port A read data, one-cycle registered
//   out_valid/out_ready  : result handshake, out_data is the FIFO head
//   spike_thr            : unsigned threshold, compared on each output handshake
//   spike, spike_cnt     : one-cycle spike pulse, saturating spike count
module if_table_lookup_ctrl #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] lut_addr,
    output logic              lut_en,
    output logic              lut_we,
    output logic [DATA_W-1:0] lut_din,
    input  logic [DATA_W-1:0] lut_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic [DATA_W-1:0] spike_thr,
    output logic              spike,
    output logic [CNT_W-1:0]  spike_cnt
);
    import if_lut_pkg::*;

    logic              accept;
    logic              pending;   // RAM read issued last cycle, data on lut_dout now
    logic              pop;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // count + pending < 2, written out as flags. Uses registered occupancy only,
    // so in_ready never depends combinationally on out_ready; a freed slot is
    // offered the cycle after the pop.
    assign in_ready = !fifo_full && !(pending && (fifo_count != 2'd0));
    assign accept   = in_valid && in_ready;

    // Address is driven straight from the input on accept and otherwise holds
    // the last issued value so the RAM pins stay quiet between reads.
    assign lut_en   = accept;
    assign lut_addr = accept ? in_data : addr_q;
    assign lut_we   = 1'b0;
    assign lut_din  = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            addr_q  <= '0;
        end else begin
            pending <= accept;
            if (accept)
                addr_q <= in_data;
        end
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Reset clears pending, so a read in flight at reset is never captured.
    if_lut_fifo2 #(.W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pending),
        .pop   (pop),
        .din   (lut_dout),
        .dout  (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef IF_LUT_SPIKE_DET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike     <= 1'b0;
            spike_cnt <= '0;
        end else begin
            spike <= 1'b0;
            if (pop && (out_data >= spike_thr)) begin
                spike <= 1'b1;
                if (spike_cnt != {CNT_W{1'b1}})
                    spike_cnt <= spike_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_spike_thr;
    assign unused_spike_thr = ^spike_thr;
    assign spike            = 1'b0;
    assign spike_cnt        = '0;
`endif
endmodule

// File: tb/tb_if_table_lookup_ctrl.sv
// tb_if_table_lookup_ctrl: randomized scoreboard bench for if_table_lookup_ctrl.
// Contains a registered-read RAM model. Accepted samples push the table value
// into a queue; a negedge monitor pops on each output handshake. Spike model
// follows IF_LUT_SPIKE_DET_EN; with it defined a 4-bit counter is used so
// saturation is reachable in a short run.
module tb_if_table_lookup_ctrl;
    localparam int DW = 12;
`ifdef IF_LUT_SPIKE_DET_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] lut_addr;
    logic          lut_en;
    logic          lut_we;
    logic [DW-1:0] lut_din;
    logic [DW-1:0] lut_dout = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [DW-1:0] spike_thr = 12'h800;
    logic          spike;
    logic [CW-1:0] spike_cnt;

    always #5 clk = ~clk;

    if_table_lookup_ctrl #(.DATA_W(DW), .ADDR_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .lut_addr(lut_addr), .lut_en(lut_en), .lut_we(lut_we),
        .lut_din(lut_din), .lut_dout(lut_dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .spike_thr(spike_thr),
        .spike(spike), .spike_cnt(spike_cnt)
    );

    // RAM port A: one-cycle registered read
    if_lut_pkg::lut_word_t mem [4096];
    always @(posedge clk) if (lut_en) lut_dout <= mem[lut_addr];

    typedef struct { logic [DW-1:0] d; int cyc; } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_en = 0, n_sent = 0, n_pulse = 0;
    int or_mode = 0;            // 0: out_ready low, 1: high, 2: random
    bit strict_lat = 0;
    logic [DW-1:0] last_addr = '0;
    logic [DW-1:0] prev_data = '0;
    bit prev_stall = 0;
    logic exp_spike = 1'b0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        bit   hs_spk;
        hs_spk = 0;
        if (!rst_n) begin
            sb.delete();
            last_addr  = '0;
            exp_spike  = 1'b0;
            exp_cnt    = '0;
            prev_stall = 0;
        end else begin
            chk("lut_we", lut_we, 0);
            chk("lut_din", lut_din, 0);
            if (in_valid && in_ready) begin
                chk("lut_en_on_accept", lut_en, 1);
                chk("lut_addr", lut_addr, in_data);
                sb.push_back('{mem[in_data], cyc});
                last_addr = in_data;
            end else begin
                chk("lut_en_idle", lut_en, 0);
                chk("lut_addr_hold", lut_addr, last_addr);
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL stale_out: got %03h expected no result (t=%0t)", out_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    if (strict_lat) chk("latency", cyc - e.cyc, 2);
                    hs_spk = (e.d >= spike_thr);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        chk("spike", spike, exp_spike);
        chk("spike_cnt", spike_cnt, exp_cnt);
        if (spike) n_pulse++;
        if (lut_en) n_en++;
`ifdef IF_LUT_SPIKE_DET_EN
        exp_spike = hs_spk;
        if (hs_spk && exp_cnt != {CW{1'b1}}) exp_cnt++;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (acc) n_sent++;
        else begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: sample %03h not accepted, expected accept", d);
        end
    endtask

    task automatic drain();
        or_mode   = 1;
        out_ready = 1'b1;
        for (int t = 0; t < 50 && (sb.size() != 0 || out_valid); t++) tick();
        tick();
        chk("drained_queue", sb.size(), 0);
        chk("drained_valid", out_valid, 0);
    endtask

    task automatic xor_table();
        for (int a = 0; a < 4096; a++) mem[a] = DW'(a) ^ 12'hFFF;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_lut_en", lut_en, 0);
        chk("rst_lut_addr", lut_addr, 0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, s0;
        xor_table();
        #2;
        chk("rst_in_ready0", in_ready, 1);
        chk("rst_lut_en0", lut_en, 0);
        chk("rst_lut_addr0", lut_addr, 0);
        chk("rst_out_valid0", out_valid, 0);
        chk("rst_out_data0", out_data, 0);
        chk("rst_spike0", spike, 0);
        chk("rst_spike_cnt0", spike_cnt, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 1: ordered stream, exact 2-cycle accept-to-handshake latency
        or_mode = 1; out_ready = 1'b1; strict_lat = 1;
        en0 = n_en;
        for (int i = 0; i < 16; i++) send(DW'(i));
        drain();
        strict_lat = 0;
        chk("t1_lut_en_count", n_en - en0, 16);

        // 2: back-pressure: only two accepts while out_ready is low
        or_mode = 0; out_ready = 1'b0;
        send(12'h123);
        send(12'h456);
        in_valid = 1'b1; in_data = 12'h789;
        repeat (4) tick();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_queued", sb.size(), 2);
        chk("bp_out_valid", out_valid, 1);
        or_mode = 1; out_ready = 1'b1;
        send(12'h789);
        drain();

        // 3: random table, random gaps, random out_ready
        for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
        en0 = n_en; s0 = n_sent;
        or_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(DW'($urandom));
        end
        drain();
        chk("t3_lut_en_count", n_en - en0, n_sent - s0);
        xor_table();

        // 4a: reset with result already buffered
        or_mode = 0; out_ready = 1'b0;
        send(12'h0AA);
        tick();
        chk("t4_buffered", out_valid, 1);
        do_reset();
        or_mode = 1;
        for (int i = 0; i < 8; i++) begin tick(); chk("t4a_no_stale", out_valid, 0); end
        // 4b: reset while the RAM read is in flight
        or_mode = 0;
        send(12'h0AA);
        do_reset();
        or_mode = 1;
        for (int i = 0; i < 8; i++) begin tick(); chk("t4b_no_stale", out_valid, 0); end
        chk("t4_in_ready", in_ready, 1);

        // 5: spike detection: outputs 0x7FF, 0x800, 0xFFF against 0x800
        do_reset();
        tick();
        n_pulse = 0;
        spike_thr = 12'h800;
        send(12'h800);
        send(12'h7FF);
        send(12'h000);
        drain();
        repeat (2) tick();
`ifdef IF_LUT_SPIKE_DET_EN
        chk("spike_pulses", n_pulse, 2);
        chk("spike_cnt_2", spike_cnt, 2);
`else
        chk("spike_pulses", n_pulse, 0);
        chk("spike_cnt_2", spike_cnt, 0);
`endif
        // 6: saturation: every output spikes
        spike_thr = 12'h000;
        for (int i = 0; i < 20; i++) send(DW'($urandom));
        drain();
        repeat (2) tick();
`ifdef IF_LUT_SPIKE_DET_EN
        chk("spike_cnt_sat", spike_cnt, {CW{1'b1}});
`else
        chk("spike_cnt_sat", spike_cnt, 0);
        chk("spike_pulses_off", n_pulse, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
